// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bus shared by the hazard unit, decode stage and instruction memory.
// master drives the requests and instruction data; slave is the fetch stage itself.
interface if_stage_if #(parameter int ADDR_WIDTH = 32);
    logic                  i_StallF;
    logic                  i_StallD;
    logic                  i_FlushD;
    logic                  i_PCSrcD;
    logic [1:0]            i_PC_SelD;
    logic [ADDR_WIDTH-1:0] i_BranchTargetD;
    logic [ADDR_WIDTH-1:0] i_RegJumpD;
    logic [31:0]           i_InstrF;
    logic [ADDR_WIDTH-1:0] o_PCF;
    logic [31:0]           o_InstrD;
    logic [5:0]            o_OpD;
    logic [5:0]            o_functD;
    logic [ADDR_WIDTH-1:0] o_PCPlus4D;
    logic                  o_ValidD;
    logic                  o_AddrErr;
    logic [31:0]           o_FetchCount;
    modport master (
        output i_StallF, i_StallD, i_FlushD, i_PCSrcD, i_PC_SelD,
               i_BranchTargetD, i_RegJumpD, i_InstrF,
        input  o_PCF, o_InstrD, o_OpD, o_functD, o_PCPlus4D,
               o_ValidD, o_AddrErr, o_FetchCount
    );
    modport slave (
        input  i_StallF, i_StallD, i_FlushD, i_PCSrcD, i_PC_SelD,
               i_BranchTargetD, i_RegJumpD, i_InstrF,
        output o_PCF, o_InstrD, o_OpD, o_functD, o_PCPlus4D,
               o_ValidD, o_AddrErr, o_FetchCount
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch - PC register, next-PC select from decode redirects,
// and the IF/ID pipeline register with valid tracking, fetch counter and misalignment flag.
module if_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic       i_clk,
    input logic       i_rst,
    if_stage_if.slave bus
);
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_pc_plus4_d;
    logic [31:0]           r_instr_d;
    logic [31:0]           r_fetch_count;
    logic                  r_valid_d;
    logic                  r_addr_err;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [ADDR_WIDTH-1:0] w_jump;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_next;
    logic                  w_misaligned;
    logic                  w_load_valid;

    assign w_pc_plus4   = r_pc + ADDR_WIDTH'(4);
    assign w_jump       = {r_pc_plus4_d[ADDR_WIDTH-1:28], r_instr_d[25:0], 2'b00};
    assign w_target     = bus.i_PC_SelD == 2'b00 ? bus.i_BranchTargetD :
                          bus.i_PC_SelD == 2'b01 ? w_jump :
                          bus.i_PC_SelD == 2'b10 ? bus.i_RegJumpD : w_pc_plus4;
    assign w_misaligned = bus.i_PCSrcD && (w_target[1:0] != 2'b00);
    // Redirect targets are forced to a word boundary; the flag records that it happened.
    assign w_next       = bus.i_PCSrcD ? {w_target[ADDR_WIDTH-1:2], 2'b00} : w_pc_plus4;
    assign w_load_valid = !bus.i_StallD && !bus.i_FlushD;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc          <= RESET_PC;
            r_instr_d     <= '0;
            r_pc_plus4_d  <= '0;
            r_valid_d     <= 1'b0;
            r_addr_err    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            if (!bus.i_StallF) r_pc <= w_next;
            if (w_misaligned) r_addr_err <= 1'b1;
            if (!bus.i_StallD) begin
                r_instr_d    <= bus.i_FlushD ? '0 : bus.i_InstrF;
                r_pc_plus4_d <= bus.i_FlushD ? '0 : w_pc_plus4;
                r_valid_d    <= !bus.i_FlushD;
            end
            if (w_load_valid) r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign bus.o_PCF        = r_pc;
    assign bus.o_InstrD     = r_instr_d;
    assign bus.o_OpD        = r_instr_d[31:26];
    assign bus.o_functD     = r_instr_d[5:0];
    assign bus.o_PCPlus4D   = r_pc_plus4_d;
    assign bus.o_ValidD     = r_valid_d;
    assign bus.o_AddrErr    = r_addr_err;
    assign bus.o_FetchCount = r_fetch_count;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: vector table with expected-result scoreboard, plus hand sequences for
// sticky error, async reset mid-stall/mid-redirect and counter wrap.
module tb_if_stage;
    typedef struct {
        string       name;
        logic        sf, sd, fl, src;
        logic [1:0]  sel;
        logic [31:0] bt, rj;
        logic [31:0] pcf, instr, pc4d;
        logic        valid, err;
        logic [31:0] cnt;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t vt[$];
    vec_t sb[$];

    if_stage_if #(.ADDR_WIDTH(32)) bus ();
    if_stage #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem(input logic [31:0] pc);
        return pc == 32'h0 ? 32'h2008_0005 : pc == 32'h4 ? 32'h0800_0010 : {16'hC0DE, pc[15:0]};
    endfunction
    assign bus.i_InstrF = mem(bus.o_PCF);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic sf, sd, fl, src,
                                input logic [1:0] sel, input logic [31:0] bt, rj, pcf, instr, pc4d,
                                input logic valid, err, input logic [31:0] cnt);
        vec_t v;
        v.name = name; v.sf = sf; v.sd = sd; v.fl = fl; v.src = src; v.sel = sel;
        v.bt = bt; v.rj = rj; v.pcf = pcf; v.instr = instr; v.pc4d = pc4d;
        v.valid = valid; v.err = err; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input logic sf, sd, fl, src, input logic [1:0] sel, input logic [31:0] bt, rj);
        bus.i_StallF = sf; bus.i_StallD = sd; bus.i_FlushD = fl; bus.i_PCSrcD = src;
        bus.i_PC_SelD = sel; bus.i_BranchTargetD = bt; bus.i_RegJumpD = rj;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pcf"}, bus.o_PCF, 32'h0);
        chk({tag, "_instr"}, bus.o_InstrD, 32'h0);
        chk({tag, "_op"}, {26'h0, bus.o_OpD}, 32'h0);
        chk({tag, "_funct"}, {26'h0, bus.o_functD}, 32'h0);
        chk({tag, "_pc4d"}, bus.o_PCPlus4D, 32'h0);
        chk({tag, "_valid"}, {31'h0, bus.o_ValidD}, 32'h0);
        chk({tag, "_err"}, {31'h0, bus.o_AddrErr}, 32'h0);
        chk({tag, "_cnt"}, bus.o_FetchCount, 32'h0);
    endtask

    initial begin
        vec_t e;
        logic [31:0] ei;
        drive(0, 0, 0, 0, 2'b00, 0, 0);
        //          name        sf sd fl src sel    bt         rj         pcf        instr          pc4d      v  err cnt
        vt.push_back(mk("rel",   0, 0, 0, 0, 2'b00, 0,         0,         32'h04, 32'h2008_0005, 32'h04, 1, 0, 1));
        vt.push_back(mk("seq",   0, 0, 0, 0, 2'b00, 0,         0,         32'h08, 32'h0800_0010, 32'h08, 1, 0, 2));
        vt.push_back(mk("jump",  0, 0, 1, 1, 2'b01, 0,         0,         32'h40, 32'h0,         32'h0,  0, 0, 2));
        vt.push_back(mk("tgt",   0, 0, 0, 0, 2'b00, 0,         0,         32'h44, 32'hC0DE_0040, 32'h44, 1, 0, 3));
        vt.push_back(mk("br",    0, 0, 1, 1, 2'b00, 32'h20,    0,         32'h20, 32'h0,         32'h0,  0, 0, 3));
        vt.push_back(mk("stl1",  1, 1, 0, 0, 2'b00, 0,         0,         32'h20, 32'h0,         32'h0,  0, 0, 3));
        vt.push_back(mk("stl2",  1, 1, 0, 0, 2'b00, 0,         0,         32'h20, 32'h0,         32'h0,  0, 0, 3));
        vt.push_back(mk("stl3",  1, 1, 0, 0, 2'b00, 0,         0,         32'h20, 32'h0,         32'h0,  0, 0, 3));
        vt.push_back(mk("run",   0, 0, 0, 0, 2'b00, 0,         0,         32'h24, 32'hC0DE_0020, 32'h24, 1, 0, 4));
        vt.push_back(mk("stfl",  1, 1, 1, 0, 2'b00, 0,         0,         32'h24, 32'hC0DE_0020, 32'h24, 1, 0, 4));
        vt.push_back(mk("flush", 0, 0, 1, 0, 2'b00, 0,         0,         32'h28, 32'h0,         32'h0,  0, 0, 4));
        vt.push_back(mk("sel11", 0, 0, 0, 1, 2'b11, 0,         0,         32'h2C, 32'hC0DE_0028, 32'h2C, 1, 0, 5));
        vt.push_back(mk("stlD",  0, 1, 0, 0, 2'b00, 32'h203,   0,         32'h30, 32'hC0DE_0028, 32'h2C, 1, 0, 5));
        vt.push_back(mk("jrmis", 0, 0, 1, 1, 2'b10, 0,         32'h102,   32'h100, 32'h0,        32'h0,  0, 1, 5));
        vt.push_back(mk("post",  0, 0, 0, 0, 2'b00, 0,         0,         32'h104, 32'hC0DE_0100, 32'h104, 1, 1, 6));
        vt.push_back(mk("post2", 0, 0, 0, 0, 2'b00, 0,         0,         32'h108, 32'hC0DE_0104, 32'h108, 1, 1, 7));

        repeat (2) @(posedge i_clk);
        #1 chk_reset("rst0");
        i_rst = 1'b0;
        foreach (vt[k]) begin
            drive(vt[k].sf, vt[k].sd, vt[k].fl, vt[k].src, vt[k].sel, vt[k].bt, vt[k].rj);
            sb.push_back(vt[k]);
            @(posedge i_clk);
            #1;
            e = sb.pop_front();
            ei = e.instr;
            chk({e.name, "_pcf"}, bus.o_PCF, e.pcf);
            chk({e.name, "_instr"}, bus.o_InstrD, e.instr);
            chk({e.name, "_op"}, {26'h0, bus.o_OpD}, {26'h0, ei[31:26]});
            chk({e.name, "_funct"}, {26'h0, bus.o_functD}, {26'h0, ei[5:0]});
            chk({e.name, "_pc4d"}, bus.o_PCPlus4D, e.pc4d);
            chk({e.name, "_valid"}, {31'h0, bus.o_ValidD}, {31'h0, e.valid});
            chk({e.name, "_err"}, {31'h0, bus.o_AddrErr}, {31'h0, e.err});
            chk({e.name, "_cnt"}, bus.o_FetchCount, e.cnt);
        end

        drive(0, 0, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            #1 chk("err_sticky", {31'h0, bus.o_AddrErr}, 32'h1);
        end

        drive(1, 1, 0, 0, 2'b00, 0, 0);
        #2 i_rst = 1'b1;
        #1 chk_reset("rst_stall");
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 0, 0);

        force dut.r_fetch_count = 32'hFFFF_FFFF;
        #1 release dut.r_fetch_count;
        #1 chk("preload_cnt", bus.o_FetchCount, 32'hFFFF_FFFF);
        @(posedge i_clk);
        #1;
        chk("wrap_cnt", bus.o_FetchCount, 32'h0);
        chk("wrap_instr", bus.o_InstrD, 32'h2008_0005);
        chk("wrap_pcf", bus.o_PCF, 32'h4);

        drive(0, 0, 1, 1, 2'b00, 32'h80, 0);
        #2 i_rst = 1'b1;
        #1 chk_reset("rst_redir");
        @(posedge i_clk);
        #1 chk("rst_hold_pcf", bus.o_PCF, 32'h0);
        i_rst = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 0, 0);
        @(posedge i_clk);
        #1;
        chk("after_rst_pcf", bus.o_PCF, 32'h4);
        chk("after_rst_cnt", bus.o_FetchCount, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
